// File: rtl/channel_err_injector_pkg.sv
// Shared types and constants for the channel error injector.
// Holds the FSM/mode enums, LFSR polynomial and counter width.
package channel_err_injector_pkg;

  localparam int CNT_W = 16;

  // Right-shift Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_RANDOM   = 2'd2,
    MODE_SINGLE   = 2'd3
  } mode_t;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/channel_err_injector_lfsr.sv
// 16-bit Galois LFSR: steps once per advance pulse, clear reloads the seed.
// State is visible directly; consumers use the value before the step.
module err_lfsr16
  import channel_err_injector_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        advance,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (clear) begin
      lfsr <= SEED;
    end else if (advance) begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/channel_err_injector.sv
// Symbol-stream error injector: periodic, random or single-shot bit flips
// inside a bounded run window; 1-cycle registered path, never stalls.
module channel_err_injector
  import channel_err_injector_pkg::*;
#(
  parameter int          W         = 2,
  parameter int          N         = 4,
  parameter int          BURST_LEN = 2,
  parameter int          WINDOW    = 256,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [W-1:0]     sym_i,
  input  logic [1:0]       mode_i,
  input  logic [W-1:0]     mask_i,
  input  logic [7:0]       rate_i,
  input  logic             start_i,
  input  logic             arm_i,
  input  logic             clear_i,
  output logic             valid_o,
  output logic [W-1:0]     sym_o,
  output logic [W-1:0]     err_mask_o,
  output logic [CNT_W-1:0] inj_count_o,
  output logic [CNT_W-1:0] bit_err_count_o,
  output logic [CNT_W-1:0] sym_count_o,
  output logic             busy_o
);

  localparam int THRESH = (1 << N) - BURST_LEN;

  if (BURST_LEN < 1 || BURST_LEN > (1 << N)) begin : g_bad_burst
    $error("BURST_LEN out of range 1..2**N");
  end
  if (WINDOW < 1 || WINDOW > 65535) begin : g_bad_window
    $error("WINDOW out of range 1..65535");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("LFSR_SEED must be non-zero");
  end

  state_t       state, state_nxt;
  logic         armed;
  logic [15:0]  lfsr;
  logic         accept;
  logic         restart;
  logic         corrupt;
  logic [W-1:0] mask_eff;

  // A clear in the same cycle as a symbol aborts the run before acceptance
  assign accept  = valid_i && (state == ST_ACTIVE) && !clear_i;
  assign restart = start_i && (state != ST_ACTIVE);
  assign busy_o  = (state == ST_ACTIVE);

  err_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear_i),
    .advance (accept),
    .lfsr    (lfsr)
  );

  always_comb begin
    corrupt = 1'b0;
    if (accept) begin
      case (mode_t'(mode_i))
        MODE_PERIODIC: corrupt = (int'(sym_count_o[N-1:0]) >= THRESH);
        MODE_RANDOM:   corrupt = (lfsr[7:0] < rate_i);
        MODE_SINGLE:   corrupt = armed;
        default:       corrupt = 1'b0;
      endcase
    end
    mask_eff = corrupt ? mask_i : '0;
  end

  always_comb begin
    state_nxt = state;
    if (clear_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start_i) state_nxt = ST_ACTIVE;
        ST_ACTIVE: if (accept && sym_count_o == CNT_W'(WINDOW - 1)) state_nxt = ST_DONE;
        ST_DONE:   if (start_i) state_nxt = ST_ACTIVE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_count_o     <= '0;
      inj_count_o     <= '0;
      bit_err_count_o <= '0;
    end else if (clear_i || restart) begin
      sym_count_o     <= '0;
      inj_count_o     <= '0;
      bit_err_count_o <= '0;
    end else if (accept) begin
      sym_count_o <= sat_add(sym_count_o, CNT_W'(1));
      if (corrupt) begin
        inj_count_o     <= sat_add(inj_count_o, CNT_W'(1));
        bit_err_count_o <= sat_add(bit_err_count_o, CNT_W'($countones(mask_i)));
      end
    end
  end

  // An arm pulse landing on the consuming symbol re-arms for the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (clear_i || restart) begin
      armed <= 1'b0;
    end else begin
      if (corrupt && mode_t'(mode_i) == MODE_SINGLE) armed <= 1'b0;
      if (arm_i) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o    <= 1'b0;
      sym_o      <= '0;
      err_mask_o <= '0;
    end else begin
      valid_o    <= valid_i;
      sym_o      <= sym_i ^ mask_eff;
      err_mask_o <= mask_eff;
    end
  end

endmodule

// File: tb/tb_channel_err_injector.sv
// Directed self-checking bench for channel_err_injector at default parameters.
module tb_channel_err_injector;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [1:0]  sym_i;
  logic [1:0]  mode_i;
  logic [1:0]  mask_i;
  logic [7:0]  rate_i;
  logic        start_i;
  logic        arm_i;
  logic        clear_i;
  logic        valid_o;
  logic [1:0]  sym_o;
  logic [1:0]  err_mask_o;
  logic [15:0] inj_count_o;
  logic [15:0] bit_err_count_o;
  logic [15:0] sym_count_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  channel_err_injector dut (
    .clk             (clk),
    .rst             (rst),
    .valid_i         (valid_i),
    .sym_i           (sym_i),
    .mode_i          (mode_i),
    .mask_i          (mask_i),
    .rate_i          (rate_i),
    .start_i         (start_i),
    .arm_i           (arm_i),
    .clear_i         (clear_i),
    .valid_o         (valid_o),
    .sym_o           (sym_o),
    .err_mask_o      (err_mask_o),
    .inj_count_o     (inj_count_o),
    .bit_err_count_o (bit_err_count_o),
    .sym_count_o     (sym_count_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  task automatic send(input logic v, input logic [1:0] s);
    valid_i = v;
    sym_i   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    send(1'b0, 2'b00);
    start_i = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    send(1'b0, 2'b00);
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b1; sym_i = 2'b11; mode_i = 2'd1; mask_i = 2'b11;
    rate_i = 8'd0; start_i = 1'b0; arm_i = 1'b0; clear_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({valid_o, sym_o, err_mask_o, busy_o} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b%b%b%b exp=000000", valid_o, sym_o, err_mask_o, busy_o);
    end
    total++;
    if ({inj_count_o, bit_err_count_o, sym_count_o} !== 48'h0) begin
      bad++;
      $display("FAIL reset_counters got=%h/%h/%h exp=0/0/0", inj_count_o, bit_err_count_o, sym_count_o);
    end
    rst = 1'b0;
    send(1'b1, 2'b10);
    total++;
    if (valid_o !== 1'b1 || sym_o !== 2'b10 || err_mask_o !== 2'b00 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL idle_passthrough got v=%b s=%b m=%b b=%b exp v=1 s=10 m=00 b=0",
               valid_o, sym_o, err_mask_o, busy_o);
    end
  endtask

  task automatic test_periodic();
    logic [1:0] s, em;
    pulse_clear();
    mode_i = 2'd1; mask_i = 2'b10;
    pulse_start();
    for (int k = 0; k < 64; k++) begin
      s  = 2'(k * 3);
      em = ((k % 16) >= 14) ? 2'b10 : 2'b00;
      send(1'b1, s);
      total++;
      if (valid_o !== 1'b1 || err_mask_o !== em || sym_o !== (s ^ em)) begin
        bad++;
        $display("FAIL periodic_sym k=%0d got v=%b s=%b m=%b exp v=1 s=%b m=%b",
                 k, valid_o, sym_o, err_mask_o, s ^ em, em);
      end
    end
    total++;
    if (inj_count_o !== 16'd8 || bit_err_count_o !== 16'd8 || sym_count_o !== 16'd64 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL periodic_counts got inj=%0d bits=%0d syms=%0d busy=%b exp 8 8 64 1",
               inj_count_o, bit_err_count_o, sym_count_o, busy_o);
    end
  endtask

  task automatic test_window();
    logic [1:0] s, em;
    logic       eb;
    pulse_clear();
    mode_i = 2'd1; mask_i = 2'b01;
    pulse_start();
    for (int k = 0; k < 300; k++) begin
      s  = 2'(k);
      em = (k < 256 && (k % 16) >= 14) ? 2'b01 : 2'b00;
      eb = (k < 255);
      send(1'b1, s);
      total++;
      if (err_mask_o !== em || sym_o !== (s ^ em) || busy_o !== eb) begin
        bad++;
        $display("FAIL window_sym k=%0d got s=%b m=%b busy=%b exp s=%b m=%b busy=%b",
                 k, sym_o, err_mask_o, busy_o, s ^ em, em, eb);
      end
    end
    total++;
    if (sym_count_o !== 16'd256 || inj_count_o !== 16'd32 || bit_err_count_o !== 16'd32) begin
      bad++;
      $display("FAIL window_counts got syms=%0d inj=%0d bits=%0d exp 256 32 32",
               sym_count_o, inj_count_o, bit_err_count_o);
    end
  endtask

  task automatic test_random();
    logic [15:0] model;
    logic [1:0]  s, em;
    int          exp_inj;
    pulse_clear();
    model = 16'hACE1;
    mode_i = 2'd2; mask_i = 2'b11; rate_i = 8'd0;
    pulse_start();
    for (int k = 0; k < 256; k++) begin
      send(1'b1, 2'(k));
      if (err_mask_o !== 2'b00) begin
        total++; bad++;
        $display("FAIL random_rate0 k=%0d got m=%b exp m=00", k, err_mask_o);
      end
      model = {1'b0, model[15:1]} ^ ({16{model[0]}} & 16'b1011_0100_0000_0000);
    end
    total++;
    if (inj_count_o !== 16'd0 || sym_count_o !== 16'd256) begin
      bad++;
      $display("FAIL random_rate0_counts got inj=%0d syms=%0d exp 0 256", inj_count_o, sym_count_o);
    end
    rate_i = 8'd255;
    pulse_start();
    exp_inj = 0;
    for (int k = 0; k < 256; k++) begin
      s  = 2'(k * 5);
      em = (model[7:0] < 8'd255) ? 2'b11 : 2'b00;
      if (em != 2'b00) exp_inj++;
      send(1'b1, s);
      total++;
      if (err_mask_o !== em || sym_o !== (s ^ em)) begin
        bad++;
        $display("FAIL random_rate255 k=%0d lfsr=%h got s=%b m=%b exp s=%b m=%b",
                 k, model, sym_o, err_mask_o, s ^ em, em);
      end
      model = {1'b0, model[15:1]} ^ ({16{model[0]}} & 16'b1011_0100_0000_0000);
    end
    total++;
    if (inj_count_o !== 16'(exp_inj) || bit_err_count_o !== 16'(2 * exp_inj)) begin
      bad++;
      $display("FAIL random_counts got inj=%0d bits=%0d exp %0d %0d",
               inj_count_o, bit_err_count_o, exp_inj, 2 * exp_inj);
    end
    rate_i = 8'd0;
  endtask

  task automatic test_single();
    logic [1:0] s, em;
    pulse_clear();
    mode_i = 2'd3; mask_i = 2'b01;
    pulse_start();
    for (int k = 0; k < 30; k++) begin
      if (k % 3 == 2) begin
        send(1'b0, 2'b11);
        total++;
        if (valid_o !== 1'b0 || err_mask_o !== 2'b00) begin
          bad++;
          $display("FAIL single_gap k=%0d got v=%b m=%b exp v=0 m=00", k, valid_o, err_mask_o);
        end
      end
      s  = 2'(k);
      em = (k == 11) ? 2'b01 : 2'b00;
      arm_i = (k == 10);
      send(1'b1, s);
      arm_i = 1'b0;
      total++;
      if (err_mask_o !== em || sym_o !== (s ^ em)) begin
        bad++;
        $display("FAIL single_sym k=%0d got s=%b m=%b exp s=%b m=%b", k, sym_o, err_mask_o, s ^ em, em);
      end
    end
    total++;
    if (inj_count_o !== 16'd1 || bit_err_count_o !== 16'd1 || sym_count_o !== 16'd30) begin
      bad++;
      $display("FAIL single_counts got inj=%0d bits=%0d syms=%0d exp 1 1 30",
               inj_count_o, bit_err_count_o, sym_count_o);
    end
  endtask

  task automatic test_clear_start();
    pulse_clear();
    mode_i = 2'd1; mask_i = 2'b11;
    pulse_start();
    for (int k = 0; k < 20; k++) send(1'b1, 2'(k));
    total++;
    if (sym_count_o !== 16'd20 || inj_count_o !== 16'd2 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL clrst_pre got syms=%0d inj=%0d busy=%b exp 20 2 1", sym_count_o, inj_count_o, busy_o);
    end
    clear_i = 1'b1; start_i = 1'b1;
    send(1'b1, 2'b01);
    clear_i = 1'b0; start_i = 1'b0;
    total++;
    if (busy_o !== 1'b0 || {inj_count_o, bit_err_count_o, sym_count_o} !== 48'h0) begin
      bad++;
      $display("FAIL clrst_state got busy=%b cnt=%h/%h/%h exp busy=0 cnt=0/0/0",
               busy_o, inj_count_o, bit_err_count_o, sym_count_o);
    end
    for (int k = 0; k < 20; k++) begin
      send(1'b1, 2'(k));
      total++;
      if (valid_o !== 1'b1 || err_mask_o !== 2'b00 || sym_o !== 2'(k) || busy_o !== 1'b0 || sym_count_o !== 16'd0) begin
        bad++;
        $display("FAIL clrst_after k=%0d got s=%b m=%b busy=%b syms=%0d exp s=%b m=00 busy=0 syms=0",
                 k, sym_o, err_mask_o, busy_o, sym_count_o, 2'(k));
      end
    end
  endtask

  task automatic test_async_reset();
    pulse_clear();
    mode_i = 2'd1; mask_i = 2'b11;
    pulse_start();
    for (int k = 0; k < 100; k++) send(1'b1, 2'(k));
    total++;
    if (inj_count_o !== 16'd12 || bit_err_count_o !== 16'd24 || sym_count_o !== 16'd100) begin
      bad++;
      $display("FAIL arst_pre got inj=%0d bits=%0d syms=%0d exp 12 24 100",
               inj_count_o, bit_err_count_o, sym_count_o);
    end
    valid_i = 1'b1; sym_i = 2'b10;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({valid_o, sym_o, err_mask_o, busy_o} !== 6'b0 ||
        {inj_count_o, bit_err_count_o, sym_count_o} !== 48'h0) begin
      bad++;
      $display("FAIL arst_immediate got v=%b s=%b m=%b busy=%b cnt=%h/%h/%h exp all 0",
               valid_o, sym_o, err_mask_o, busy_o, inj_count_o, bit_err_count_o, sym_count_o);
    end
    #2 rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      send(1'b1, 2'(k + 1));
      total++;
      if (valid_o !== 1'b1 || sym_o !== 2'(k + 1) || err_mask_o !== 2'b00 || busy_o !== 1'b0) begin
        bad++;
        $display("FAIL arst_after k=%0d got v=%b s=%b m=%b busy=%b exp v=1 s=%b m=00 busy=0",
                 k, valid_o, sym_o, err_mask_o, busy_o, 2'(k + 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_window();
    test_random();
    test_single();
    test_clear_start();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/channel_err_injector.md
CHANNEL_ERR_INJECTOR -- requirements
Module: channel_err_injector

Interface
REQ-001 Parameter: W, default 2, symbol width in bits (encoder output width).
REQ-002 Parameter: N, default 4, log2 of the periodic-burst period.
REQ-003 Parameter: BURST_LEN, default 2, corrupted symbols per period; legal range 1..2**N.
REQ-004 Parameter: WINDOW, default 256, accepted symbols per run during which injection is permitted.
REQ-005 Parameter: LFSR_SEED, default 16'hACE1, non-zero LFSR reset value.
REQ-006 Ports: one clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 valid_i  in  1  sym_i carries a symbol this cycle.
REQ-010 sym_i  in  W  clean encoder symbol.
REQ-011 mode_i  in  2  0=off, 1=periodic burst, 2=random, 3=single-shot.
REQ-012 mask_i  in  W  bit positions flipped when a symbol is corrupted.
REQ-013 rate_i  in  8  random-mode threshold; corrupt when lfsr[7:0] < rate_i.
REQ-014 start_i  in  1  pulse; begins a run.
REQ-015 arm_i  in  1  pulse; arms single-shot mode.
REQ-016 clear_i  in  1  pulse; aborts run, zeroes counters.
REQ-017 valid_o  out  1  sym_o valid.
REQ-018 sym_o  out  W  possibly corrupted symbol.
REQ-019 err_mask_o  out  W  bits actually flipped in sym_o (zero when clean).
REQ-020 inj_count_o  out  16  corrupted symbols this run, saturating at 16'hFFFF.
REQ-021 bit_err_count_o  out  16  total flipped bits this run, saturating.
REQ-022 sym_count_o  out  16  accepted symbols this run, saturating.
REQ-023 busy_o  out  1  high in state ACTIVE.

Function
REQ-024 Latency exactly 1 cycle: valid_o(t+1)=valid_i(t); sym_o(t+1)=sym_i(t)^err_mask_o(t+1); no stalls or backpressure.
REQ-025 FSM states: IDLE, ACTIVE, DONE; IDLE->ACTIVE on start_i; ACTIVE->DONE on acceptance of symbol WINDOW-1 (0-based); DONE->ACTIVE on start_i; any state->IDLE on clear_i.
REQ-026 Symbols pass clean (mask 0) in IDLE and DONE; valid_o still follows valid_i.
REQ-027 Only symbols with valid_i=1 in ACTIVE are accepted; sym_count_o increments per accepted symbol; symbol index k = count before increment.
REQ-028 Periodic mode: corrupt accepted symbol k when k[N-1:0] >= 2**N-BURST_LEN (defaults: k mod 16 in {14,15}).
REQ-029 Random mode: 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, advances once per accepted symbol in any mode; decision uses pre-advance value.
REQ-030 Single-shot mode: arm_i sets armed flag; next accepted symbol is corrupted and flag clears; arm_i coincident with acceptance applies to the following symbol.
REQ-031 Mode 0 never corrupts; mode_i sampled per accepted symbol, changes apply immediately.
REQ-032 Corrupted symbol: err_mask_o=mask_i; inj_count_o +1; bit_err_count_o + popcount(mask_i); mask_i=0 counts as an injection with 0 bits.
REQ-033 start_i in ACTIVE is ignored; start_i from IDLE/DONE zeroes all three counters and the armed flag; LFSR not reseeded.
REQ-034 clear_i and start_i same cycle: clear wins; clear_i also reseeds LFSR to LFSR_SEED.
REQ-035 Counters saturate, never wrap; sym_count_o wrap of k is not possible because WINDOW <= 65535 (elaboration check).

Reset
REQ-036 On rst: state IDLE, valid_o=0, sym_o=0, err_mask_o=0, all counters 0, busy_o=0, armed=0, LFSR=LFSR_SEED.
REQ-037 Reset mid-run abandons the run; first post-reset symbol passes clean until start_i.

Structure
REQ-038 Shared package holds FSM state enum, mode enum, LFSR tap constant, counter width constant.
REQ-039 One sub-module, err_lfsr16 (seed, advance, clear), instantiated once; remainder flat.

Verification
REQ-040 Periodic defaults, start, 64 back-to-back valid symbols, mask 2'b10 -> indices 14,15,30,31,46,47,62,63 flipped in bit1; inj_count 8, bit_err_count 8.
REQ-041 Periodic, WINDOW=256, 300 symbols -> busy_o drops after symbol 255, symbols 256..299 clean, sym_count_o=256, inj_count_o=32.
REQ-042 Random, rate_i=0 -> zero injections over 256 symbols; rate_i=255 with mask 2'b11 -> injections match reference LFSR model exactly.
REQ-043 Single-shot, arm_i at symbol 10 with valid gaps -> exactly one corrupted symbol (next accepted), inj_count_o=1.
REQ-044 clear_i and start_i together at symbol 20 -> state IDLE, counters 0, subsequent symbols clean.
REQ-045 rst asserted mid-run at symbol 100 -> all outputs 0 immediately (async), clean pass-through after release.
